// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
// Holds the divider FSM state encoding, the default operand width and a
// helper that sizes the iteration counter for a given width.
package arith_pkg;

  localparam int unsigned DefaultW = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Counter must be able to hold the values 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sub_step.sv
// One restoring-division step: trial subtract plus restore mux.
// Ports:
//   rem     - shifted partial remainder (W+1 bits)
//   dvs     - divisor (W bits, zero-extended internally)
//   rem_nxt - next partial remainder (trial if non-negative, else rem)
//   qbit    - quotient bit produced by this step
module sub_step #(
  parameter int unsigned W = 4
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_nxt,
  output logic         qbit
);

  logic [W:0] trial;

  always_comb begin
    trial   = rem - {1'b0, dvs};
    // MSB clear means the subtraction did not borrow.
    qbit    = ~trial[W];
    rem_nxt = qbit ? trial : rem;
  end

endmodule

// File: rtl/seqdiv_subaccu.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   ck, rst      - clock and synchronous active-high reset
//   start        - request a division (ignored while busy)
//   a, b         - dividend and divisor, captured on the accepting edge
//   q, r         - quotient and remainder of the last completed operation
//   busy         - iteration in progress
//   done         - one-cycle pulse when q/r/dbz are newly updated
//   dbz          - last completed operation had a zero divisor
module seqdiv_subaccu
  import arith_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         dbz
);

  localparam int unsigned CW = cnt_width(W);
  localparam logic [CW-1:0] LastCnt = CW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;

  logic [W:0]    shifted;
  logic [W:0]    step_rem;
  logic          step_qbit;
  logic          accept;

  // The remainder is always below the divisor, so its top bit is zero and
  // dropping it in the shift loses nothing.
  assign shifted = (W + 1)'({rem_q, dvd_q[W-1]});

  sub_step #(
    .W(W)
  ) u_sub_step (
    .rem     (shifted),
    .dvs     (dvs_q),
    .rem_nxt (step_rem),
    .qbit    (step_qbit)
  );

  assign accept = start && (state_q != StRun);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    case (state_q)
      StRun: begin
        dvd_d = dvd_q << 1;
        rem_d = step_rem;
        quo_d = (quo_q << 1) | W'(step_qbit);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          q_d     = quo_d;
          r_d     = step_rem[W-1:0];
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // Accepting from DONE overrides the return to IDLE: back-to-back ops.
    if (accept) begin
      dvd_d = a;
      dvs_d = b;
      rem_d = '0;
      quo_d = '0;
      cnt_d = '0;
      if (b == '0) begin
        state_d = StDone;
        q_d     = '1;
        r_d     = a;
        dbz_d   = 1'b1;
      end else begin
        state_d = StRun;
        dbz_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_seqdiv_subaccu.sv
module tb_seqdiv_subaccu;

  localparam int unsigned W = 4;

  logic         ck = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dbz;

  int tests = 0;
  int fails = 0;

  seqdiv_subaccu #(
    .W(W)
  ) dut (
    .ck    (ck),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // Issue one op and wait for done. lat counts edges after the accepting
  // edge; nbusy counts cycles seen busy while waiting.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output int oq, output int orr, output int odbz,
                        output int lat, output int nbusy);
    start = 1'b1;
    a     = ia;
    b     = ib;
    step();
    start = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      step();
      lat++;
    end
    oq   = int'(q);
    orr  = int'(r);
    odbz = int'(dbz);
  endtask

  initial begin
    int rq, rr, rd, lat, nb, pulses;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    check_eq("reset_q", int'(q), 0);
    check_eq("reset_r", int'(r), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_done", int'(done), 0);
    check_eq("reset_dbz", int'(dbz), 0);
    rst = 1'b0;
    step();

    // 13/3
    run_op(4'd13, 4'd3, rq, rr, rd, lat, nb);
    check_eq("t1_lat", lat, 4);
    check_eq("t1_busy_cycles", nb, 4);
    check_eq("t1_q", rq, 4);
    check_eq("t1_r", rr, 1);
    check_eq("t1_dbz", rd, 0);
    step();
    check_eq("t1_done_one_cycle", int'(done), 0);
    step();

    // 15/1 then 2/7 started in the DONE cycle
    run_op(4'd15, 4'd1, rq, rr, rd, lat, nb);
    check_eq("t2a_lat", lat, 4);
    check_eq("t2a_q", rq, 15);
    check_eq("t2a_r", rr, 0);
    run_op(4'd2, 4'd7, rq, rr, rd, lat, nb);
    check_eq("t2b_lat", lat, 4);
    check_eq("t2b_q", rq, 0);
    check_eq("t2b_r", rr, 2);
    step();

    // 9/0 then 8/2
    run_op(4'd9, 4'd0, rq, rr, rd, lat, nb);
    check_eq("t3a_lat", lat, 0);
    check_eq("t3a_q", rq, 15);
    check_eq("t3a_r", rr, 9);
    check_eq("t3a_dbz", rd, 1);
    step();
    run_op(4'd8, 4'd2, rq, rr, rd, lat, nb);
    check_eq("t3b_lat", lat, 4);
    check_eq("t3b_q", rq, 4);
    check_eq("t3b_r", rr, 0);
    check_eq("t3b_dbz", rd, 0);
    step();

    // 12/5 with a start pulse during RUN that must be ignored
    start = 1'b1;
    a     = 4'd12;
    b     = 4'd5;
    step();
    start = 1'b0;
    step();
    check_eq("t4_busy_mid", int'(busy), 1);
    start = 1'b1;
    a     = 4'd5;
    b     = 4'd1;
    step();
    start  = 1'b0;
    pulses = 0;
    rq     = -1;
    rr     = -1;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        rq = int'(q);
        rr = int'(r);
      end
      step();
    end
    check_eq("t4_pulses", pulses, 1);
    check_eq("t4_q", rq, 2);
    check_eq("t4_r", rr, 2);

    // 11/2 interrupted by reset at iteration 2
    start = 1'b1;
    a     = 4'd11;
    b     = 4'd2;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t5_q", int'(q), 0);
    check_eq("t5_r", int'(r), 0);
    check_eq("t5_busy", int'(busy), 0);
    check_eq("t5_done", int'(done), 0);
    check_eq("t5_dbz", int'(dbz), 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      step();
    end
    check_eq("t5_no_done", pulses, 0);
    run_op(4'd11, 4'd2, rq, rr, rd, lat, nb);
    check_eq("t5b_q", rq, 5);
    check_eq("t5b_r", rr, 1);
    step();

    // Exhaustive sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_op(W'(ia), W'(ib), rq, rr, rd, lat, nb);
        if (ib == 0) begin
          check_eq($sformatf("sweep_dbz_q_%0d", ia), rq, 15);
          check_eq($sformatf("sweep_dbz_r_%0d", ia), rr, ia);
          check_eq($sformatf("sweep_dbz_flag_%0d", ia), rd, 1);
        end else begin
          check_eq($sformatf("sweep_inv_%0d_%0d", ia, ib),
                   int'((rq * ib + rr == ia) && (rr < ib)), 1);
          check_eq($sformatf("sweep_flag_%0d_%0d", ia, ib), rd, 0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
